// File: rtl/dmem_responder.sv
// Data-memory responder for the RV64 core: fixed-latency load/store with byte lanes,
// load extension and misalignment detection, holding the pipeline via stall.
module dmem_responder #(
   parameter int DEPTH_WORDS = 512,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic [63:0] rdata,
   output logic        stall,
   output logic        done,
   output logic        err
);

   localparam int IW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state, next_state;
   logic [CW-1:0]   count, next_count;
   logic            fire;
   logic            request;

   logic            req_read, req_write;
   logic [2:0]      req_f3;
   logic [IW+2:0]   req_addr;
   logic [63:0]     req_wdata;
   logic            err_q;

   logic [63:0]     mem [DEPTH_WORDS];

   logic            src_read, src_write;
   logic [2:0]      src_f3;
   logic [IW+2:0]   src_addr;
   logic [63:0]     src_wdata;

   logic [IW-1:0]   idx;
   logic [2:0]      off;
   logic [5:0]      shift;
   logic            misaligned;
   logic            illegal;
   logic [63:0]     lane_mask;
   logic [63:0]     word;
   logic [63:0]     shifted;
   logic [63:0]     load_val;
   logic [63:0]     store_word;

   logic            unused_addr;

   assign request     = mem_read | mem_write;
   assign unused_addr = ^addr[63:IW+3];

   always_comb begin
      next_state = state;
      next_count = count;
      fire       = 1'b0;
      stall      = 1'b0;
      unique case (state)
         IDLE: begin
            if (request) begin
               stall = 1'b1;
               if (LATENCY == 1) begin
                  next_state = DONE;
                  fire       = 1'b1;
               end else begin
                  next_state = BUSY;
                  next_count = CW'(LATENCY - 1);
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (count <= CW'(1)) begin
               next_state = DONE;
               fire       = 1'b1;
            end else begin
               next_count = count - CW'(1);
            end
         end
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         rdata <= '0;
         err_q <= 1'b0;
      end else begin
         state <= next_state;
         count <= next_count;
         if (fire) begin
            err_q <= illegal;
            if (illegal)
               rdata <= '0;
            else if (src_read)
               rdata <= load_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && request) begin
         req_read  <= mem_read;
         req_write <= mem_write;
         req_f3    <= funct3;
         req_addr  <= addr[IW+2:0];
         req_wdata <= wdata;
      end
   end

   // With LATENCY=1 the access happens on the accept edge, before the latch holds anything.
   always_comb begin
      if (state == IDLE) begin
         src_read  = mem_read;
         src_write = mem_write;
         src_f3    = funct3;
         src_addr  = addr[IW+2:0];
         src_wdata = wdata;
      end else begin
         src_read  = req_read;
         src_write = req_write;
         src_f3    = req_f3;
         src_addr  = req_addr;
         src_wdata = req_wdata;
      end
   end

   assign idx   = src_addr[IW+2:3];
   assign off   = src_addr[2:0];
   assign shift = {off, 3'b000};
   assign word  = mem[idx];

   always_comb begin
      misaligned = 1'b0;
      lane_mask  = 64'hFF;
      unique case (src_f3[1:0])
         2'b00: begin misaligned = 1'b0;       lane_mask = 64'h0000_0000_0000_00FF; end
         2'b01: begin misaligned = off[0];     lane_mask = 64'h0000_0000_0000_FFFF; end
         2'b10: begin misaligned = |off[1:0];  lane_mask = 64'h0000_0000_FFFF_FFFF; end
         default: begin misaligned = |off;     lane_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
      endcase
   end

   assign illegal = (src_read & src_write)
                  | (src_read & (src_f3 == 3'b111))
                  | (src_write & src_f3[2])
                  | misaligned;

   // src_f3[2] clear means sign-extend the loaded lanes.
   always_comb begin
      shifted  = word >> shift;
      load_val = '0;
      unique case (src_f3[1:0])
         2'b00: load_val = src_f3[2] ? {56'b0, shifted[7:0]}
                                     : {{56{shifted[7]}}, shifted[7:0]};
         2'b01: load_val = src_f3[2] ? {48'b0, shifted[15:0]}
                                     : {{48{shifted[15]}}, shifted[15:0]};
         2'b10: load_val = src_f3[2] ? {32'b0, shifted[31:0]}
                                     : {{32{shifted[31]}}, shifted[31:0]};
         default: load_val = shifted;
      endcase
   end

   assign store_word = (word & ~(lane_mask << shift))
                     | ((src_wdata & lane_mask) << shift);

   always_ff @(posedge clk) begin
      if (!reset && fire && src_write && !illegal)
         mem[idx] <= store_word;
   end

   always_comb begin
      done = (state == DONE);
      err  = (state == DONE) & err_q;
   end

endmodule
